// File: rtl/beat_period_counter.sv
// Purpose: counts CLK cycles spanned by N consecutive beat periods (DETECT pulses)
// and presents the count through a VALID/ACK handshake.
// Latency: VALID rises one cycle after the final DETECT, or one cycle after the
// counter saturates.
// Backpressure: a finished result is held in DONE until ACK. START is ignored while BUSY.
// Ports:
//   CLK, RESETB        clock, asynchronous active-low reset
//   START, N_BEATS     measurement request and beat count (0 is treated as 1)
//   DETECT             beat-edge pulse from the edge detector
//   ACK                result consumed (honoured only in DONE)
//   RESULT, OVF        measured cycle count and saturation flag (registered)
//   VALID, BUSY        decoded from the registered state
module beat_period_counter #(
  parameter int CNT_W = 16,
  parameter int NB_W  = 4
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             START,
  input  logic             DETECT,
  input  logic [NB_W-1:0]  N_BEATS,
  input  logic             ACK,
  output logic [CNT_W-1:0] RESULT,
  output logic             VALID,
  output logic             OVF,
  output logic             BUSY
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NB_W-1:0]  NB_ONE  = {{(NB_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          beats_d = (N_BEATS == '0) ? NB_ONE : N_BEATS;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // The arming edge counts as cycle 1 of the first period.
        if (DETECT) begin
          cnt_d   = CNT_ONE;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // The final edge wins over saturation when both land in the same cycle.
        if (DETECT && beats_q == NB_ONE) begin
          result_d = cnt_q;
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          result_d = CNT_MAX;
          ovf_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (DETECT) begin
            beats_d = beats_q - NB_ONE;
          end
        end
      end
      default: begin
        if (ACK) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      beats_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beats_q  <= beats_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign RESULT = result_q;
  assign OVF    = ovf_q;
  assign VALID  = (state_q == ST_DONE);
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_beat_period_counter.sv
module tb_beat_period_counter;

  localparam int CNT_W = 8;
  localparam int NB_W  = 4;

  logic             CLK;
  logic             RESETB;
  logic             START;
  logic             DETECT;
  logic [NB_W-1:0]  N_BEATS;
  logic             ACK;
  logic [CNT_W-1:0] RESULT;
  logic             VALID;
  logic             OVF;
  logic             BUSY;

  beat_period_counter #(.CNT_W(CNT_W), .NB_W(NB_W)) dut (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .START   (START),
    .DETECT  (DETECT),
    .N_BEATS (N_BEATS),
    .ACK     (ACK),
    .RESULT  (RESULT),
    .VALID   (VALID),
    .OVF     (OVF),
    .BUSY    (BUSY)
  );

  typedef struct {
    int res;
    int ovf;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_vld = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each rising VALID consumes one expected result from the scoreboard.
  always @(negedge CLK) begin
    if (RESETB && VALID && !prev_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: VALID rose at cycle %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", int'(RESULT), e.res);
        chk("ovf", int'(OVF), e.ovf);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
    prev_vld <= RESETB && VALID;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic start_meas(input int nb);
    N_BEATS = NB_W'(nb);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic detect_pulse();
    DETECT = 1'b1;
    tick();
    DETECT = 1'b0;
  endtask

  task automatic push_exp(input int res, input int ovf, input int c);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!VALID && n < maxc) begin
      tick();
      n++;
    end
    if (!VALID) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: VALID still low after %0d cycles, required high", maxc);
    end
  endtask

  task automatic do_ack();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    chk("valid_after_ack", int'(VALID), 0);
    chk("busy_after_ack", int'(BUSY), 0);
  endtask

  // Arms on the first DETECT, then issues max(nb,1) further edges spaced sp cycles apart.
  task automatic run_meas(input int nb, input int sp);
    int eff;
    eff = (nb == 0) ? 1 : nb;
    start_meas(nb);
    gap(2);
    detect_pulse();
    for (int i = 0; i < eff; i++) begin
      gap(sp - 1);
      if (i == eff - 1) push_exp(sp * eff, 0, cyc + 1);
      detect_pulse();
    end
    wait_valid(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETB  = 1'b0;
    START   = 1'b0;
    DETECT  = 1'b0;
    N_BEATS = '0;
    ACK     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_result", int'(RESULT), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_busy", int'(BUSY), 0);
    RESETB = 1'b1;
    tick();

    // DETECT ignored in IDLE
    detect_pulse();
    chk("idle_detect_busy", int'(BUSY), 0);

    // Single period, spacing 10
    run_meas(1, 10);
    do_ack();

    // Four periods of 7; extra DETECTs in DONE are ignored
    run_meas(4, 7);
    detect_pulse();
    gap(2);
    detect_pulse();
    chk("done_hold_result", int'(RESULT), 28);
    chk("done_hold_valid", int'(VALID), 1);
    do_ack();

    // N_BEATS=0 behaves as one period
    run_meas(0, 12);
    do_ack();

    // Saturation with no closing edge
    start_meas(1);
    gap(2);
    detect_pulse();
    push_exp(255, 1, cyc + 255);
    wait_valid(300);
    chk("sat_ovf", int'(OVF), 1);
    do_ack();

    // Reset mid-COUNT clears everything immediately
    start_meas(1);
    gap(2);
    detect_pulse();
    gap(40);
    #2;
    RESETB = 1'b0;
    #1;
    chk("midrst_result", int'(RESULT), 0);
    chk("midrst_valid", int'(VALID), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_ovf", int'(OVF), 0);
    @(posedge CLK);
    #1;
    RESETB = 1'b1;
    tick();
    run_meas(1, 9);
    do_ack();

    // Final edge lands exactly on the saturation cycle
    start_meas(1);
    gap(2);
    detect_pulse();
    gap(254);
    push_exp(255, 0, cyc + 1);
    detect_pulse();
    wait_valid(5);
    do_ack();

    // START/ACK ignored in ARM, COUNT, DONE
    start_meas(2);
    gap(1);
    START = 1'b1;
    ACK = 1'b1;
    tick();
    START = 1'b0;
    ACK = 1'b0;
    chk("arm_busy", int'(BUSY), 1);
    detect_pulse();
    gap(2);
    START = 1'b1;
    tick();
    START = 1'b0;
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    gap(5);
    detect_pulse();
    gap(9);
    push_exp(20, 0, cyc + 1);
    detect_pulse();
    wait_valid(5);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("done_start_valid", int'(VALID), 1);
    chk("done_start_result", int'(RESULT), 20);

    // START coincident with ACK starts nothing
    START = 1'b1;
    ACK = 1'b1;
    tick();
    START = 1'b0;
    ACK = 1'b0;
    chk("ackstart_valid", int'(VALID), 0);
    chk("ackstart_busy", int'(BUSY), 0);
    gap(2);
    chk("ackstart_idle", int'(BUSY), 0);

    // Reasserted START begins a fresh measurement
    N_BEATS = NB_W'(1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("restart_busy", int'(BUSY), 1);
    gap(1);
    detect_pulse();
    gap(5);
    push_exp(6, 0, cyc + 1);
    detect_pulse();
    wait_valid(5);
    do_ack();

    gap(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_period_counter.md
Name: beat_period_counter

Overview:
- Sits directly downstream of the stacked edge detector in the odometer_stacked path.
- Consumes the single-cycle DETECT pulses, which mark beat edges of the stressed-vs-reference oscillator pair.
- Measures the number of CLK cycles spanned by N consecutive beat periods.
- Presents the result through a VALID/ACK handshake to the readout/scan logic.

Parameters:
- CNT_W, 16, width of the period counter and RESULT; the counter saturates at 2^CNT_W-1.
- NB_W, 4, width of the N_BEATS input.

Ports:
- CLK  input  1  sampling clock; the same clock that drives the edge detector.
- RESETB  input  1  asynchronous active-low reset.
- START  input  1  level/pulse request to begin a measurement; sampled only in IDLE.
- DETECT  input  1  beat-edge pulse from the edge detector; one CLK cycle wide, minimum spacing 3 cycles.
- N_BEATS  input  NB_W  number of beat periods to accumulate; sampled on START; 0 is treated as 1.
- ACK  input  1  result consumed; honoured only while VALID=1.
- RESULT  output  CNT_W  measured cycle count.
- VALID  output  1  RESULT and OVF are stable and readable.
- OVF  output  1  counter saturated before the Nth beat edge arrived.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (RESETB=0, asynchronous):
  - state=IDLE.
  - RESULT=0, VALID=0, OVF=0, BUSY=0.
  - Internal counter and beats_left are cleared.
  - A reset mid-measurement abandons that measurement; there is no partial result.
- State IDLE:
  - START=1 loads beats_left = (N_BEATS==0 ? 1 : N_BEATS) and moves to ARM.
  - DETECT and ACK are ignored.
- State ARM (waiting for the reference edge):
  - DETECT=1 at cycle t0 sets cnt<=1 and moves to COUNT.
  - ARM has no timeout; it waits indefinitely.
- State COUNT:
  - Each cycle, cnt<=cnt+1.
  - On DETECT=1 with beats_left>1: beats_left<=beats_left-1; counting continues without a restart.
  - On DETECT=1 with beats_left==1: RESULT<=cnt, OVF<=0, go to DONE.
  - At the final edge cycle t1, RESULT = t1-t0 cycles in total across all N periods.
- Saturation, evaluated in COUNT:
  - If cnt == 2^CNT_W-1 and no final DETECT occurs in that cycle: RESULT<=2^CNT_W-1, OVF<=1, go to DONE.
  - A final DETECT arriving in that same cycle takes priority: normal result, OVF=0.
- State DONE:
  - VALID=1; RESULT and OVF are held.
  - ACK=1 moves to IDLE; VALID=0 from the next cycle.
  - RESULT and OVF are retained until the next measurement completes.
- START is ignored while BUSY=1; no queuing.
  - START=1 in the same cycle that ACK returns the block to IDLE is not honoured; it is sampled again in IDLE.
- ACK is ignored outside DONE.
- DETECT pulses are ignored in IDLE and DONE.
- Latency: VALID rises 1 cycle after the final DETECT (registered).
- Outputs:
  - BUSY and VALID are decoded from registered state; no combinational path from inputs to outputs.
  - RESULT and OVF are registers.
- All arithmetic is unsigned; the counter never wraps.

Test Plan:
- Reset, START with N_BEATS=1, DETECT pulses at cycles 5 and 15 -> VALID=1 at cycle 16, RESULT=10, OVF=0; ACK -> VALID=0 next cycle, BUSY=0.
- N_BEATS=4, DETECT every 7 cycles starting at cycle 3 -> RESULT=28 one cycle after the 5th DETECT (cycle 31); extra DETECTs in DONE leave RESULT unchanged.
- N_BEATS=0, DETECT spacing 12 -> treated as 1 period, RESULT=12.
- CNT_W=8, START then a single DETECT with no further edges -> 255 cycles after the arming DETECT: VALID=1, RESULT=255, OVF=1. Repeat with the final DETECT landing exactly on the saturation cycle -> RESULT=255, OVF=0.
- Assert RESETB=0 mid-COUNT (cnt≈40) -> immediately RESULT=0, VALID=0, BUSY=0, OVF=0; after release, a fresh measurement with spacing 9 gives RESULT=9.
- START pulsed in ARM/COUNT/DONE and ACK pulsed in ARM/COUNT -> no state change; the measurement completes with the correct RESULT; START coincident with the ACK cycle starts nothing until it is reasserted.
